// File: rtl/cc_branch_ctrl.sv
// Condition-code register and branch/return control for the execute stage.
// Evaluates jump/cmov conditions from the stored flags, detects mispredicted
// jumps and returns, and sequences the pipeline control pulses that follow.
module cc_branch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        e_valid,
   input  logic [3:0]  e_icode,
   input  logic [3:0]  e_ifun,
   input  logic [2:0]  alu_flags,
   input  logic        exc_pending,
   output logic [2:0]  cc,
   output logic        e_cnd,
   output logic        bad_ifun,
   output logic        flush_de,
   output logic        stall_f,
   output logic        bubble_d,
   output logic [15:0] mispred_cnt
);

   localparam logic [3:0] IcodeCmovxx = 4'd2;
   localparam logic [3:0] IcodeOpq    = 4'd6;
   localparam logic [3:0] IcodeJxx    = 4'd7;
   localparam logic [3:0] IcodeRet    = 4'd9;

   localparam logic [2:0]  CcReset  = 3'b010;
   localparam logic [15:0] CntMax   = 16'hFFFF;
   localparam logic [1:0]  RcntLoad = 2'd2;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSquash  = 2'd1,
      StRetwait = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] rcnt_q, rcnt_d;

   logic       flag_of, flag_zf, flag_sf;
   logic       lt;
   logic       cond_raw;
   logic       is_branch;
   logic       is_jxx;
   logic       is_opq;
   logic       is_ret;
   logic       misp;
   logic       rete;
   logic       cc_load;
   logic       enter_squash;

   // Instruction class decode; ifun is deliberately not part of it.
   always_comb begin
      is_jxx    = e_valid & (e_icode == IcodeJxx);
      is_branch = e_valid & ((e_icode == IcodeJxx) | (e_icode == IcodeCmovxx));
      is_opq    = e_valid & (e_icode == IcodeOpq);
      is_ret    = e_valid & (e_icode == IcodeRet);
   end

   // Condition evaluation from the stored flags, never from the live ALU flags.
   always_comb begin
      flag_of  = cc[0];
      flag_zf  = cc[1];
      flag_sf  = cc[2];
      lt       = flag_sf ^ flag_of;
      cond_raw = 1'b0;
      case (e_ifun)
         4'd0:    cond_raw = 1'b1;
         4'd1:    cond_raw = lt | flag_zf;
         4'd2:    cond_raw = lt;
         4'd3:    cond_raw = flag_zf;
         4'd4:    cond_raw = ~flag_zf;
         4'd5:    cond_raw = ~lt;
         4'd6:    cond_raw = ~lt & ~flag_zf;
         default: cond_raw = 1'b0;
      endcase
      e_cnd    = is_branch & cond_raw;
      bad_ifun = is_branch & (e_ifun > 4'd6);
   end

   // Pipeline events; jumps are predicted taken, so a false condition mispredicts.
   always_comb begin
      misp = is_jxx & ~e_cnd & ~exc_pending;
      rete = is_ret & ~exc_pending;
   end

   // Flags are not updated by an instruction that is being squashed or that
   // sits behind a faulting instruction.
   always_comb begin
      cc_load = is_opq & ~exc_pending & ~flush_de;
   end

   // Condition-code register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc <= CcReset;
      end else if (cc_load) begin
         cc <= alu_flags;
      end
   end

   // FSM state and return-wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rcnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Next-state logic; events are only honoured in StIdle.
   always_comb begin
      state_d      = state_q;
      rcnt_d       = rcnt_q;
      enter_squash = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (misp) begin
               state_d      = StSquash;
               enter_squash = 1'b1;
            end else if (rete) begin
               state_d = StRetwait;
               rcnt_d  = RcntLoad;
            end
         end
         StSquash: begin
            state_d = StIdle;
         end
         StRetwait: begin
            if (rcnt_q == 2'd0) begin
               state_d = StIdle;
            end else begin
               rcnt_d = rcnt_q - 2'd1;
            end
         end
         default: begin
            state_d = StIdle;
            rcnt_d  = 2'd0;
         end
      endcase
   end

   // Control outputs are pure decodes of the registered state.
   always_comb begin
      flush_de = 1'b0;
      stall_f  = 1'b0;
      bubble_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            flush_de = 1'b0;
         end
         StSquash: begin
            flush_de = 1'b1;
         end
         StRetwait: begin
            stall_f  = 1'b1;
            bubble_d = 1'b1;
         end
         default: begin
            flush_de = 1'b0;
         end
      endcase
   end

   // Saturating mispredict counter, bumped on each entry into StSquash.
   always_ff @(posedge clk) begin
      if (rst) begin
         mispred_cnt <= 16'd0;
      end else if (enter_squash && (mispred_cnt != CntMax)) begin
         mispred_cnt <= mispred_cnt + 16'd1;
      end
   end

endmodule
